// File: rtl/pipemem_ctrl_if.sv
//==============================================================================
// Module      : pipemem_ctrl_if
// Description : Word-wide request/acknowledge data-memory bus
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface pipemem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/pipemem_ctrl.sv
//==============================================================================
// Module      : pipemem_ctrl
// Description : MEM-stage controller - EXE/MEM and MEM/WB registers, memory
//               request FSM with stall, misalignment drop and timeout abort
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module pipemem_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  ewreg,
    input  logic                  em2reg,
    input  logic                  ewmem,
    input  logic [31:0]           ealu,
    input  logic [31:0]           eb,
    input  logic [4:0]            ern,
    output logic                  mstall,
    pipemem_ctrl_if.master        mem,
    output logic                  wwreg,
    output logic                  wm2reg,
    output logic [31:0]           walu,
    output logic [31:0]           wmo,
    output logic [4:0]            wrn,
    output logic                  maddr_err,
    output logic                  mem_timeout
);

    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_BUSY      = 1'b1;
    localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        mwreg_q, mwreg_d, mm2reg_q, mm2reg_d, mwmem_q, mwmem_d;
    logic [31:0] malu_q, malu_d, mb_q, mb_d;
    logic [4:0]  mrn_q, mrn_d;
    logic        wwreg_q, wwreg_d, wm2reg_q, wm2reg_d;
    logic [31:0] walu_q, walu_d, wmo_q, wmo_d;
    logic [4:0]  wrn_q, wrn_d;
    logic        maddr_err_q, maddr_err_d, mem_timeout_q, mem_timeout_d;

    logic w_busy, w_wait, w_last, w_adv, w_memop, w_mis;

    assign w_busy  = (state_q == c_BUSY);
    assign w_wait  = w_busy & ~mem.mem_ack;
    assign w_last  = (wcnt_q == c_WAIT_LAST);
    assign w_adv   = ~(w_wait & ~w_last);
    assign w_memop = em2reg | ewmem;
    assign w_mis   = w_memop & (ealu[1:0] != 2'b00);

    // State register, shared with the pipeline registers it sequences
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= c_IDLE;
            wcnt_q        <= 8'd0;
            mwreg_q       <= 1'b0;
            mm2reg_q      <= 1'b0;
            mwmem_q       <= 1'b0;
            malu_q        <= 32'd0;
            mb_q          <= 32'd0;
            mrn_q         <= 5'd0;
            wwreg_q       <= 1'b0;
            wm2reg_q      <= 1'b0;
            walu_q        <= 32'd0;
            wmo_q         <= 32'd0;
            wrn_q         <= 5'd0;
            maddr_err_q   <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            mwreg_q       <= mwreg_d;
            mm2reg_q      <= mm2reg_d;
            mwmem_q       <= mwmem_d;
            malu_q        <= malu_d;
            mb_q          <= mb_d;
            mrn_q         <= mrn_d;
            wwreg_q       <= wwreg_d;
            wm2reg_q      <= wm2reg_d;
            walu_q        <= walu_d;
            wmo_q         <= wmo_d;
            wrn_q         <= wrn_d;
            maddr_err_q   <= maddr_err_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next state: a new aligned memory op always (re)enters BUSY on advance
    always_comb begin
        state_d = state_q;
        if (w_adv) begin
            state_d = (w_memop && !w_mis) ? c_BUSY : c_IDLE;
        end
    end

    always_comb begin
        mstall        = w_wait & ~w_last;
        mem.mem_req   = w_busy;
        mem.mem_we    = mwmem_q;
        mem.mem_addr  = malu_q;
        mem.mem_wdata = mb_q;
    end

    always_comb begin
        wcnt_d        = wcnt_q;
        mwreg_d       = mwreg_q;
        mm2reg_d      = mm2reg_q;
        mwmem_d       = mwmem_q;
        malu_d        = malu_q;
        mb_d          = mb_q;
        mrn_d         = mrn_q;
        wwreg_d       = wwreg_q;
        wm2reg_d      = wm2reg_q;
        walu_d        = walu_q;
        wmo_d         = wmo_q;
        wrn_d         = wrn_q;
        maddr_err_d   = maddr_err_q | (w_adv & w_mis);
        mem_timeout_d = mem_timeout_q | (w_wait & w_last);
        if (w_adv) begin
            // A timed-out access still retires, but must not write the register file
            wwreg_d  = mwreg_q & ~(w_wait & w_last);
            wm2reg_d = mm2reg_q;
            walu_d   = malu_q;
            wmo_d    = mem.mem_rdata;
            wrn_d    = mrn_q;
            mwreg_d  = ewreg & ~w_mis;
            mm2reg_d = em2reg & ~w_mis;
            mwmem_d  = ewmem & ~w_mis;
            malu_d   = ealu;
            mb_d     = eb;
            mrn_d    = ern;
            wcnt_d   = 8'd0;
        end else begin
            wwreg_d = 1'b0;
            wcnt_d  = wcnt_q + 8'd1;
        end
    end

    assign wwreg       = wwreg_q;
    assign wm2reg      = wm2reg_q;
    assign walu        = walu_q;
    assign wmo         = wmo_q;
    assign wrn         = wrn_q;
    assign maddr_err   = maddr_err_q;
    assign mem_timeout = mem_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_pipemem_ctrl.sv
//==============================================================================
// Module      : tb_pipemem_ctrl
// Description : Directed self-checking bench for pipemem_ctrl
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pipemem_ctrl;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ewreg, em2reg, ewmem;
    logic [31:0] ealu, eb;
    logic [4:0]  ern;
    logic        mstall, wwreg, wm2reg, maddr_err, mem_timeout;
    logic [31:0] walu, wmo;
    logic [4:0]  wrn;

    int n_checks = 0;
    int n_errors = 0;

    pipemem_ctrl_if mif ();

    pipemem_ctrl #(.MAX_WAIT(16)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .ewreg       (ewreg),
        .em2reg      (em2reg),
        .ewmem       (ewmem),
        .ealu        (ealu),
        .eb          (eb),
        .ern         (ern),
        .mstall      (mstall),
        .mem         (mif),
        .wwreg       (wwreg),
        .wm2reg      (wm2reg),
        .walu        (walu),
        .wmo         (wmo),
        .wrn         (wrn),
        .maddr_err   (maddr_err),
        .mem_timeout (mem_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_e(input logic wr, input logic ld, input logic st,
                         input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
        ewreg  = wr;
        em2reg = ld;
        ewmem  = st;
        ealu   = alu;
        eb     = b;
        ern    = rn;
    endtask

    initial begin
        resetn        = 1'b0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'd0;
        set_e(0, 0, 0, 0, 0, 0);
        tick();
        #1;
        check("rst_req",     {31'd0, mif.mem_req}, 32'd0);
        check("rst_stall",   {31'd0, mstall},      32'd0);
        check("rst_wwreg",   {31'd0, wwreg},       32'd0);
        check("rst_wm2reg",  {31'd0, wm2reg},      32'd0);
        check("rst_aerr",    {31'd0, maddr_err},   32'd0);
        check("rst_tmo",     {31'd0, mem_timeout}, 32'd0);
        check("rst_walu",    walu,                 32'd0);
        resetn = 1'b1;
        tick();

        // ALU op passes through in one cycle per stage
        set_e(1, 0, 0, 32'h1234, 0, 5);
        #1 check("alu_stall0", {31'd0, mstall}, 32'd0);
        tick();
        set_e(0, 0, 0, 0, 0, 0);
        #1 check("alu_stall1", {31'd0, mstall}, 32'd0);
        check("alu_noreq", {31'd0, mif.mem_req}, 32'd0);
        tick();
        #1 check("alu_wwreg", {31'd0, wwreg}, 32'd1);
        check("alu_walu", walu, 32'h1234);
        check("alu_wrn", {27'd0, wrn}, 32'd5);

        // Load acked on the third request cycle
        set_e(1, 1, 0, 32'h100, 0, 7);
        tick();
        set_e(0, 0, 0, 0, 0, 0);
        #1 check("ld_req1", {31'd0, mif.mem_req}, 32'd1);
        check("ld_we", {31'd0, mif.mem_we}, 32'd0);
        check("ld_addr", mif.mem_addr, 32'h100);
        check("ld_stall1", {31'd0, mstall}, 32'd1);
        tick();
        #1 check("ld_req2", {31'd0, mif.mem_req}, 32'd1);
        check("ld_stall2", {31'd0, mstall}, 32'd1);
        check("ld_bubble", {31'd0, wwreg}, 32'd0);
        tick();
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hDEADBEEF;
        #1 check("ld_req3", {31'd0, mif.mem_req}, 32'd1);
        check("ld_stall3", {31'd0, mstall}, 32'd0);
        tick();
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'd0;
        #1 check("ld_wwreg", {31'd0, wwreg}, 32'd1);
        check("ld_wm2reg", {31'd0, wm2reg}, 32'd1);
        check("ld_wmo", wmo, 32'hDEADBEEF);
        check("ld_wrn", {27'd0, wrn}, 32'd7);
        check("ld_reqdone", {31'd0, mif.mem_req}, 32'd0);

        // Back-to-back stores with ack tied high
        mif.mem_ack = 1'b1;
        set_e(0, 0, 1, 32'h10, 32'hAA, 0);
        tick();
        set_e(0, 0, 1, 32'h14, 32'hBB, 0);
        #1 check("st1_req", {31'd0, mif.mem_req}, 32'd1);
        check("st1_we", {31'd0, mif.mem_we}, 32'd1);
        check("st1_addr", mif.mem_addr, 32'h10);
        check("st1_wdata", mif.mem_wdata, 32'hAA);
        check("st1_stall", {31'd0, mstall}, 32'd0);
        tick();
        set_e(0, 0, 0, 0, 0, 0);
        #1 check("st2_req", {31'd0, mif.mem_req}, 32'd1);
        check("st2_addr", mif.mem_addr, 32'h14);
        check("st2_wdata", mif.mem_wdata, 32'hBB);
        check("st2_stall", {31'd0, mstall}, 32'd0);
        tick();
        #1 check("st_idle_req", {31'd0, mif.mem_req}, 32'd0);
        check("st_no_aerr", {31'd0, maddr_err}, 32'd0);
        mif.mem_ack = 1'b0;

        // Misaligned load is dropped, following instruction unaffected
        set_e(1, 1, 0, 32'h102, 0, 9);
        tick();
        set_e(1, 0, 0, 32'h55, 0, 3);
        #1 check("mis_noreq", {31'd0, mif.mem_req}, 32'd0);
        check("mis_aerr", {31'd0, maddr_err}, 32'd1);
        check("mis_stall", {31'd0, mstall}, 32'd0);
        tick();
        set_e(0, 0, 0, 0, 0, 0);
        #1 check("mis_wwreg", {31'd0, wwreg}, 32'd0);
        tick();
        #1 check("mis_next_wwreg", {31'd0, wwreg}, 32'd1);
        check("mis_next_walu", walu, 32'h55);
        check("mis_next_wrn", {27'd0, wrn}, 32'd3);
        check("mis_sticky", {31'd0, maddr_err}, 32'd1);

        // Load with no ack times out after 16 request cycles
        set_e(1, 1, 0, 32'h200, 0, 4);
        tick();
        set_e(0, 0, 0, 0, 0, 0);
        #1 check("tmo_pre", {31'd0, mem_timeout}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tmo_req%0d", i), {31'd0, mif.mem_req}, 32'd1);
            check($sformatf("tmo_stall%0d", i), {31'd0, mstall}, (i < 15) ? 32'd1 : 32'd0);
            tick();
            #1;
        end
        check("tmo_flag", {31'd0, mem_timeout}, 32'd1);
        check("tmo_wwreg", {31'd0, wwreg}, 32'd0);
        check("tmo_idle", {31'd0, mif.mem_req}, 32'd0);
        check("tmo_nostall", {31'd0, mstall}, 32'd0);

        // Reset asserted during the second BUSY cycle
        set_e(1, 1, 0, 32'h300, 0, 6);
        tick();
        set_e(0, 0, 0, 0, 0, 0);
        tick();
        #1 check("rmid_req", {31'd0, mif.mem_req}, 32'd1);
        resetn = 1'b0;
        #1 check("rmid_req0", {31'd0, mif.mem_req}, 32'd0);
        check("rmid_stall0", {31'd0, mstall}, 32'd0);
        check("rmid_aerr0", {31'd0, maddr_err}, 32'd0);
        check("rmid_tmo0", {31'd0, mem_timeout}, 32'd0);
        check("rmid_wwreg0", {31'd0, wwreg}, 32'd0);
        check("rmid_walu0", walu, 32'd0);
        check("rmid_wmo0", wmo, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        set_e(1, 0, 0, 32'h77, 0, 2);
        tick();
        set_e(0, 0, 0, 0, 0, 0);
        #1 check("post_stall", {31'd0, mstall}, 32'd0);
        tick();
        #1 check("post_wwreg", {31'd0, wwreg}, 32'd1);
        check("post_walu", walu, 32'h77);
        check("post_wrn", {27'd0, wrn}, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
